// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : request FSM states (IDLE, WAIT, DROP)
//   if_entry_t    : one buffered fetch {instr, pc, err}
package if_pkg;

  localparam int PKG_N = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [PKG_N-1:0] PC_INC    = 32'd4;
  localparam logic [PKG_N-1:0] INSTR_NOP = 32'h0;

  typedef struct packed {
    logic [PKG_N-1:0] instr;
    logic [PKG_N-1:0] pc;
    logic             err;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of fetched entries.
//   clk, rst (async, active high)
//   push/push_data : write one entry
//   pop            : retire the head entry
//   flush          : empty the FIFO (wins over push/pop)
//   head           : registered head entry (storage read through rd_ptr)
//   count          : number of valid entries, 0..DEPTH
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  if_entry_t               push_data,
  input  logic                    pop,
  input  logic                    flush,
  output if_entry_t               head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage is reset to zero so the head reads as an all-zero entry
  // straight out of reset.
  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the decode/execute core.
// Issues one outstanding word request at a time to instruction memory,
// buffers returned words with their PCs and hands them to decode through
// a valid/ready handshake. A REDIRECT pulse flushes everything and restarts
// fetch at REDIRECT_PC.
//   clk, rst                 : clock, async active-high reset
//   IM_REQ/IM_ADDR           : memory request and word address
//   IM_ACK/IM_RDATA          : memory completion and data
//   REDIRECT/REDIRECT_PC     : restart pulse and target
//   ID_READY                 : decode accepts head entry
//   IF_VALID/IF_INSTR/IF_PC/IF_PC4 : head entry towards decode
//   IF_ERR                   : head entry is a misaligned-target marker
//                              (only with IF_FETCH_ERR_EN defined)
// Build option IF_FETCH_ERR_EN: a misaligned redirect target produces one
// error entry instead of a fetch, then halts fetch until the next redirect.
// Without it the target's low two bits are forced to zero.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int           N         = 32,
  parameter int           IM_ADDR_W = 16,
  parameter int           DEPTH     = 2,
  parameter logic [N-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 IM_REQ,
  output logic [IM_ADDR_W-1:0] IM_ADDR,
  input  logic                 IM_ACK,
  input  logic [N-1:0]         IM_RDATA,
  input  logic                 REDIRECT,
  input  logic [N-1:0]         REDIRECT_PC,
  input  logic                 ID_READY,
  output logic                 IF_VALID,
  output logic [N-1:0]         IF_INSTR,
  output logic [N-1:0]         IF_PC,
  output logic [N-1:0]         IF_PC4
`ifdef IF_FETCH_ERR_EN
  ,
  output logic                 IF_ERR
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t         state, state_nx;
  logic [N-1:0]         fetch_pc, fetch_pc_nx;
  logic [N-1:0]         redirect_tgt;
  logic [IM_ADDR_W-1:0] req_addr;
  logic                 push, pop;
  if_entry_t            push_data, head;
  logic [CW-1:0]        count;
  logic                 halt, err_pend;

`ifdef IF_FETCH_ERR_EN
  logic misaligned;
  assign misaligned   = REDIRECT_PC[1:0] != 2'b00;
  assign redirect_tgt = REDIRECT_PC;

  // err_pend lasts the single cycle after a misaligned redirect (the cycle
  // the marker entry is pushed); halt holds fetch off until a new redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt     <= 1'b0;
      err_pend <= 1'b0;
    end else if (REDIRECT) begin
      halt     <= misaligned;
      err_pend <= misaligned;
    end else begin
      err_pend <= 1'b0;
    end
  end
`else
  logic [1:0] unused_rpc_lo;
  assign unused_rpc_lo = REDIRECT_PC[1:0];
  assign redirect_tgt  = {REDIRECT_PC[N-1:2], 2'b00};
  assign halt          = 1'b0;
  assign err_pend      = 1'b0;
`endif

  // Redirect overrides any pop in the same cycle.
  assign pop = IF_VALID && ID_READY && !REDIRECT;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    push        = 1'b0;
    push_data   = '{instr: IM_RDATA, pc: fetch_pc, err: 1'b0};
    unique case (state)
      // Only issue when a slot is guaranteed free for the response.
      IDLE: if (!REDIRECT && !halt && !err_pend && count < CW'(DEPTH))
              state_nx = WAIT;
      WAIT: begin
        if (REDIRECT) begin
          // The access cannot be cancelled; without the ACK in hand we
          // must wait out the stale response in DROP.
          state_nx = IM_ACK ? IDLE : DROP;
        end else if (IM_ACK) begin
          push        = 1'b1;
          fetch_pc_nx = fetch_pc + PC_INC;
          state_nx    = IDLE;
        end
      end
      DROP: if (IM_ACK) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (err_pend && !REDIRECT) begin
      push      = 1'b1;
      push_data = '{instr: INSTR_NOP, pc: fetch_pc, err: 1'b1};
    end
    if (REDIRECT) fetch_pc_nx = redirect_tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC[IM_ADDR_W+1:2];
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      // Latch the address at issue so it stays put through DROP even
      // though fetch_pc has already moved to the redirect target.
      if (state == IDLE && state_nx == WAIT)
        req_addr <= fetch_pc[IM_ADDR_W+1:2];
    end
  end

  assign IM_REQ  = state != IDLE;
  assign IM_ADDR = req_addr;

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (REDIRECT),
    .head      (head),
    .count     (count)
  );

  assign IF_VALID = count != '0;
  assign IF_INSTR = head.instr;
  assign IF_PC    = head.pc;
  assign IF_PC4   = head.pc + PC_INC;

`ifdef IF_FETCH_ERR_EN
  assign IF_ERR = head.err;
`else
  logic unused_err;
  assign unused_err = head.err;
`endif

endmodule
